maj_data_sampler: RTL and testbench
===================================

Name: maj_data_sampler

Overview:
Parametrised successor to the UART RX 3-sample data sampler. Takes NUM_SAMPLES oversampled readings of RX_IN, centred on the middle of each bit period, and majority-votes them into one recovered bit. Adds an input synchroniser, registered outputs, a noise flag and a configuration-error flag. Sits between the RX edge/bit counter and the deserializer / start / parity / stop checkers in the UART RX.

Parameters:
PRESCALE_W, 6, width of the edge-count and prescale buses; supports prescale up to 2^PRESCALE_W-1.
NUM_SAMPLES, 3, samples per bit; odd, 1..7.
SYNC_STAGES, 2, flops on the RX_IN synchroniser; 0 means bypass.

Ports:
MSamp_CLK  in  1  oversampling clock; single clock domain.
MSamp_RST  in  1  reset; asynchronous assert, active-low.
MSamp_edge_cnt  in  PRESCALE_W  oversample edge index within the current bit, 0..prescale-1.
MSamp_prescale  in  PRESCALE_W  oversampling ratio; even, >= 2*NUM_SAMPLES.
MSamp_data_samp_en  in  1  sampling enable from the RX FSM.
MSamp_RX_IN  in  1  raw serial line.
MSamp_sample  out  1  majority-voted bit.
MSamp_sample_valid  out  1  one-cycle strobe qualifying MSamp_sample.
MSamp_noise_err  out  1  samples disagreed; valid with the strobe.
MSamp_cfg_err  out  1  prescale too small for the sample window.

Behaviour:
- Reset: all outputs 0; ones counter, sample index and synchroniser flops 0. Reset is asynchronous and active-low; it aborts any partial window.
- rx_s is RX_IN delayed by SYNC_STAGES flops. All votes use rx_s.
- Window: centre = prescale>>1; half = NUM_SAMPLES>>1; start = centre-half, clamped at 0; last = start+NUM_SAMPLES-1.
- cfg_err is registered and updated every cycle: 1 when last > prescale-1 or prescale < 2*NUM_SAMPLES. While cfg_err=1, no sample is taken and valid stays 0.
- Internal state:
  - samp_idx, width clog2(NUM_SAMPLES+1): index of the next sample expected.
  - ones_cnt, same width: count of 1s taken so far.
- Take condition: data_samp_en & ~cfg_err & (edge_cnt == start+samp_idx).
  - On take: ones_cnt += rx_s; samp_idx += 1.
  - Each index is taken at most once, so a stalled edge_cnt does not double-count.
- Completion: a take with samp_idx == NUM_SAMPLES-1 (the final one).
  - Next cycle: sample_valid=1 for exactly one cycle.
  - sample = (final ones total > half).
  - noise_err = (total != 0 and total != NUM_SAMPLES).
  - samp_idx and ones_cnt clear to 0 in the same cycle.
  - Latency: 1 clock from the final sample edge to the strobe.
- Abort (samp_idx and ones_cnt clear to 0, no strobe):
  - data_samp_en=0;
  - edge_cnt==0 with samp_idx!=0 (bit boundary, covers a skipped edge);
  - edge_cnt > start+samp_idx with samp_idx!=0 (expected edge missed).
- When no strobe is issued, sample and noise_err hold their last strobed value. Consumers use them only under valid.
- Enable drop on the final edge: no take, no strobe.
- Prescale change mid-window is not supported; the miss/abort rules recover within one bit.
- NUM_SAMPLES=1: single sample at centre, noise_err is always 0.
- Width rules: window arithmetic is done in PRESCALE_W+1 bits so start+samp_idx cannot wrap.

Decomposition:
- Shared package uart_rx_pkg: default PRESCALE_W, the MAX_SAMPLES=7 limit, and a clog2 function. It is also used by the edge counter and the RX FSM.
- One sub-module, bit_sync (parametrised SYNC_STAGES-flop synchroniser with async active-low reset), instantiated for RX_IN.
- Vote, window and index logic live in maj_data_sampler.

Test Plan:
- NUM_SAMPLES=3, SYNC_STAGES=0, prescale=8, edge_cnt 0..7, en=1, RX=1 throughout -> takes at edges 3,4,5; valid=1 for one cycle after edge 5; sample=1, noise_err=0.
- Same setup, RX=1,0,1 on edges 3,4,5 -> sample=1, noise_err=1. Then RX=0,1,0 -> sample=0, noise_err=1.
- NUM_SAMPLES=5, prescale=16 -> takes at edges 6..10. With RX=1,1,0,0,0: sample=0, noise_err=1, valid one cycle after edge 10.
- SYNC_STAGES=2, prescale=8: RX toggles 1 to 0 at cycle t -> votes reflect the new value 2 cycles later; valid timing is still edge 5 plus 1.
- en deasserted at edge 4, or edge_cnt held at 4 for 3 cycles then resumes -> first case: no valid strobe and state cleared; second case: valid after edge 5 with the stalled sample counted once.
- prescale=4 with NUM_SAMPLES=3 -> cfg_err=1, no valid. Assert MSamp_RST mid-window -> all outputs 0 immediately, and the next full window produces exactly one valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive path: the edge counter, the RX FSM
// and the majority-vote data sampler.
//   DEF_PRESCALE_W : default width of the edge-count / prescale buses
//   MAX_SAMPLES    : largest supported samples-per-bit (odd, 1..7)
//   clog2()        : ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DEF_PRESCALE_W = 6;
    localparam int MAX_SAMPLES    = 7;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// STAGES-flop synchroniser for a single asynchronous input. STAGES = 0
// turns it into a plain wire.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : input delayed by STAGES clocks
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            // Clock and reset are intentionally unused in bypass mode.
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, rst_n};
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] sr;

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the value its predecessor held before the edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/maj_data_sampler.sv
// ---------------------------------------------------------------------------
// maj_data_sampler
// Takes NUM_SAMPLES oversampled readings of the (synchronised) serial line,
// centred on the middle of each bit period, and majority-votes them into one
// recovered bit. Results are registered and qualified by a one-cycle strobe.
//   MSamp_CLK          : oversampling clock
//   MSamp_RST          : asynchronous active-low reset
//   MSamp_edge_cnt     : oversample edge index inside the current bit
//   MSamp_prescale     : oversampling ratio (even, >= 2*NUM_SAMPLES)
//   MSamp_data_samp_en : sampling enable from the RX FSM
//   MSamp_RX_IN        : raw serial line
//   MSamp_sample       : majority-voted bit, valid with the strobe
//   MSamp_sample_valid : one-cycle strobe, one clock after the final sample
//   MSamp_noise_err    : samples of the bit disagreed, valid with the strobe
//   MSamp_cfg_err      : prescale too small for the sample window
// ---------------------------------------------------------------------------
module maj_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = DEF_PRESCALE_W,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  MSamp_CLK,
    input  logic                  MSamp_RST,
    input  logic [PRESCALE_W-1:0] MSamp_edge_cnt,
    input  logic [PRESCALE_W-1:0] MSamp_prescale,
    input  logic                  MSamp_data_samp_en,
    input  logic                  MSamp_RX_IN,
    output logic                  MSamp_sample,
    output logic                  MSamp_sample_valid,
    output logic                  MSamp_noise_err,
    output logic                  MSamp_cfg_err
);

    localparam int CNT_W = clog2(NUM_SAMPLES + 1);
    // One extra bit so start + samp_idx can never wrap.
    localparam int AW    = PRESCALE_W + 1;

    localparam logic [AW-1:0]    HALF_A   = AW'(NUM_SAMPLES / 2);
    localparam logic [AW-1:0]    NS_A     = AW'(NUM_SAMPLES);
    localparam logic [AW-1:0]    TWO_NS_A = AW'(2 * NUM_SAMPLES);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(NUM_SAMPLES / 2);
    localparam logic [CNT_W-1:0] NS_C     = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    logic             rx_s;
    logic [CNT_W-1:0] samp_idx;
    logic [CNT_W-1:0] ones_cnt;

    logic [AW-1:0]    prescale_x;
    logic [AW-1:0]    edge_x;
    logic [AW-1:0]    centre;
    logic [AW-1:0]    win_start;
    logic [AW-1:0]    win_last;
    logic [AW-1:0]    expected_edge;
    logic [CNT_W-1:0] ones_total;
    logic             cfg_bad;
    logic             take;
    logic             take_final;
    logic             abort;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (MSamp_CLK),
        .rst_n (MSamp_RST),
        .d     (MSamp_RX_IN),
        .q     (rx_s)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        prescale_x    = {1'b0, MSamp_prescale};
        edge_x        = {1'b0, MSamp_edge_cnt};
        centre        = prescale_x >> 1;
        win_start     = '0;
        win_last      = '0;
        expected_edge = '0;
        ones_total    = ones_cnt + CNT_W'(rx_s);
        cfg_bad       = 1'b0;
        take          = 1'b0;
        take_final    = 1'b0;
        abort         = 1'b0;

        if (centre >= HALF_A) begin
            win_start = centre - HALF_A;
        end
        win_last      = win_start + NS_A - AW'(1);
        // last > prescale-1 written as last >= prescale to avoid underflow.
        cfg_bad       = (win_last >= prescale_x) || (prescale_x < TWO_NS_A);
        expected_edge = win_start + AW'(samp_idx);

        take       = MSamp_data_samp_en && !MSamp_cfg_err && (edge_x == expected_edge);
        take_final = take && (samp_idx == LAST_IDX);
        // A bit boundary or a skipped expected edge drops a partial window.
        abort      = !MSamp_data_samp_en ||
                     ((samp_idx != '0) && ((edge_x == '0) || (edge_x > expected_edge)));
    end

    always_ff @(posedge MSamp_CLK or negedge MSamp_RST) begin
        if (!MSamp_RST) begin
            samp_idx           <= '0;
            ones_cnt           <= '0;
            MSamp_sample       <= 1'b0;
            MSamp_sample_valid <= 1'b0;
            MSamp_noise_err    <= 1'b0;
            MSamp_cfg_err      <= 1'b0;
        end else begin
            MSamp_cfg_err      <= cfg_bad;
            MSamp_sample_valid <= take_final;

            if (take_final) begin
                MSamp_sample    <= (ones_total > HALF_C);
                MSamp_noise_err <= (ones_total != '0) && (ones_total != NS_C);
                samp_idx        <= '0;
                ones_cnt        <= '0;
            end else if (take) begin
                samp_idx <= samp_idx + CNT_W'(1);
                ones_cnt <= ones_total;
            end else if (abort) begin
                samp_idx <= '0;
                ones_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_maj_data_sampler.sv
// ---------------------------------------------------------------------------
// tb_maj_data_sampler
// Three sampler instances share one clock and reset:
//   0 : NUM_SAMPLES=3, SYNC_STAGES=0
//   1 : NUM_SAMPLES=5, SYNC_STAGES=0
//   2 : NUM_SAMPLES=3, SYNC_STAGES=2
// Expected strobes (instance, cycle, sample, noise) are queued when the final
// sample edge is driven and popped by a monitor when a strobe appears.
// ---------------------------------------------------------------------------
module tb_maj_data_sampler;

    localparam int PW = 6;

    typedef struct {
        int dut;
        int cyc;
        bit sample;
        bit noise;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] edge_cnt [3];
    logic [PW-1:0] prescale [3];
    logic          en       [3];
    logic          rx       [3];
    logic          samp     [3];
    logic          vld      [3];
    logic          nerr     [3];
    logic          cerr     [3];

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    maj_data_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(0)) u_dut0 (
        .MSamp_CLK(clk), .MSamp_RST(rst_n), .MSamp_edge_cnt(edge_cnt[0]),
        .MSamp_prescale(prescale[0]), .MSamp_data_samp_en(en[0]), .MSamp_RX_IN(rx[0]),
        .MSamp_sample(samp[0]), .MSamp_sample_valid(vld[0]),
        .MSamp_noise_err(nerr[0]), .MSamp_cfg_err(cerr[0]));

    maj_data_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5), .SYNC_STAGES(0)) u_dut1 (
        .MSamp_CLK(clk), .MSamp_RST(rst_n), .MSamp_edge_cnt(edge_cnt[1]),
        .MSamp_prescale(prescale[1]), .MSamp_data_samp_en(en[1]), .MSamp_RX_IN(rx[1]),
        .MSamp_sample(samp[1]), .MSamp_sample_valid(vld[1]),
        .MSamp_noise_err(nerr[1]), .MSamp_cfg_err(cerr[1]));

    maj_data_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(2)) u_dut2 (
        .MSamp_CLK(clk), .MSamp_RST(rst_n), .MSamp_edge_cnt(edge_cnt[2]),
        .MSamp_prescale(prescale[2]), .MSamp_data_samp_en(en[2]), .MSamp_RX_IN(rx[2]),
        .MSamp_sample(samp[2]), .MSamp_sample_valid(vld[2]),
        .MSamp_noise_err(nerr[2]), .MSamp_cfg_err(cerr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check($sformatf("spurious_valid_dut%0d", d), 32'(vld[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_dut",   32'(d),       32'(e.dut));
                    check("strobe_cycle", 32'(cyc),     32'(e.cyc));
                    check("sample",       32'(samp[d]), 32'(e.sample));
                    check("noise_err",    32'(nerr[d]), 32'(e.noise));
                end
            end
        end
    end

    // One bit period of edges 0..ps-1 with rx[d] = rxv[edge]. drop_edge
    // deasserts enable on that edge; stall_edge repeats that edge.
    task automatic run_window(input int d, input int ps, input int ns, input int sync,
                              input logic [15:0] rxv, input int drop_edge,
                              input int stall_edge, input int stall_extra);
        int  start;
        int  ones;
        int  reps;
        bit  strobe;
        exp_t e;
        start = ps / 2 - ns / 2;
        if (start < 0) start = 0;
        ones = 0;
        // The vote sees the line as it was sync cycles earlier.
        for (int k = 0; k < ns; k++) ones += int'(rxv[start + k - sync]);
        strobe = (drop_edge < 0) && (ps >= 2 * ns) && (start + ns - 1 <= ps - 1);
        for (int ed = 0; ed < ps; ed++) begin
            reps = (ed == stall_edge) ? 1 + stall_extra : 1;
            for (int r = 0; r < reps; r++) begin
                edge_cnt[d] = PW'(ed);
                en[d]       = (ed != drop_edge);
                rx[d]       = rxv[ed];
                if (strobe && r == 0 && ed == start + ns - 1) begin
                    e.dut    = d;
                    e.cyc    = cyc + 1;
                    e.sample = (ones > ns / 2);
                    e.noise  = (ones != 0) && (ones != ns);
                    sb.push_back(e);
                end
                tick();
            end
        end
        en[d] = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            edge_cnt[d] = '0;
            en[d]       = 1'b0;
            rx[d]       = 1'b0;
        end
        prescale[0] = 6'd8;
        prescale[1] = 6'd16;
        prescale[2] = 6'd8;

        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_sample%0d", d), 32'(samp[d]), 32'd0);
            check($sformatf("rst_valid%0d", d),  32'(vld[d]),  32'd0);
            check($sformatf("rst_noise%0d", d),  32'(nerr[d]), 32'd0);
            check($sformatf("rst_cfg%0d", d),    32'(cerr[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic votes, 3 samples, edges 3,4,5.
        run_window(0, 8, 3, 0, 16'hFFFF, -1, -1, 0);  // 1,1,1
        run_window(0, 8, 3, 0, 16'h0028, -1, -1, 0);  // 1,0,1
        run_window(0, 8, 3, 0, 16'h0010, -1, -1, 0);  // 0,1,0

        // 5 samples at edges 6..10.
        run_window(1, 16, 5, 0, 16'h00C0, -1, -1, 0); // 1,1,0,0,0
        run_window(1, 16, 5, 0, 16'h0000, -1, -1, 0); // all zero

        // Synchronised line: 1->0 after edge 2 shows up two cycles late.
        run_window(2, 8, 3, 2, 16'h0007, -1, -1, 0);

        // Enable drop mid-window, then a clean window.
        run_window(0, 8, 3, 0, 16'hFFFF, 4, -1, 0);
        check("drop_no_strobe", 32'(sb.size()), 32'd0);
        run_window(0, 8, 3, 0, 16'h0010, -1, -1, 0);

        // Edge 4 stalled for 3 cycles: its sample counts once.
        run_window(0, 8, 3, 0, 16'h0010, -1, 4, 2);

        // Configuration limits.
        prescale[0] = 6'd4;
        repeat (2) tick();
        check("cfg_err_ps4", 32'(cerr[0]), 32'd1);
        run_window(0, 4, 3, 0, 16'hFFFF, -1, -1, 0);
        prescale[0] = 6'd6;
        repeat (2) tick();
        check("cfg_err_ps6", 32'(cerr[0]), 32'd0);
        run_window(0, 6, 3, 0, 16'h0014, -1, -1, 0);  // edges 2,3,4 = 1,0,1
        prescale[0] = 6'd8;
        prescale[1] = 6'd8;
        repeat (2) tick();
        check("cfg_err_ns5_ps8", 32'(cerr[1]), 32'd1);
        prescale[1] = 6'd10;
        repeat (2) tick();
        check("cfg_err_ns5_ps10", 32'(cerr[1]), 32'd0);
        prescale[1] = 6'd8;
        repeat (2) tick();

        // Leave non-zero outputs, then reset in the middle of a window.
        run_window(0, 8, 3, 0, 16'h0028, -1, -1, 0);
        for (int ed = 0; ed < 5; ed++) begin
            edge_cnt[0] = PW'(ed);
            en[0]       = 1'b1;
            rx[0]       = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sample", 32'(samp[0]), 32'd0);
        check("mid_rst_noise",  32'(nerr[0]), 32'd0);
        check("mid_rst_valid",  32'(vld[0]),  32'd0);
        check("mid_rst_cfg1",   32'(cerr[1]), 32'd0);
        en[0] = 1'b0;
        prescale[1] = 6'd16;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        run_window(0, 8, 3, 0, 16'hFFFF, -1, -1, 0);

        repeat (3) tick();
        check("pending_strobes", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
